// File: rtl/multiplier_pipe_floating_point32_pkg.sv
// Shared FP32 field constants, result classes and the special-case priority
// helper for the pipelined single-precision multiplier.
package multiplier_pipe_floating_point32_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } result_class_e;

    // NaN (including 0 x inf) outranks infinity, which outranks zero.
    function automatic result_class_e classify_result(
        input logic zero_a, input logic inf_a, input logic nan_a,
        input logic zero_b, input logic inf_b, input logic nan_b
    );
        result_class_e cls;
        if (nan_a || nan_b || (zero_a && inf_b) || (inf_a && zero_b)) begin
            cls = CLS_NAN;
        end else if (inf_a || inf_b) begin
            cls = CLS_INF;
        end else if (zero_a || zero_b) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/multiplier_pipe_floating_point32_classify.sv
// Combinational FP32 operand classifier; denormals are reported as zero.
module fp32_operand_classify
    import multiplier_pipe_floating_point32_pkg::*;
(
    input  logic [30:0] mag_i,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o
);

    logic [7:0]  exp_s;
    logic [22:0] frac_s;

    assign exp_s     = mag_i[30:23];
    assign frac_s    = mag_i[22:0];
    assign is_zero_o = (exp_s == 8'd0);
    assign is_inf_o  = (exp_s == 8'(EXP_MAX)) && (frac_s == 23'd0);
    assign is_nan_o  = (exp_s == 8'(EXP_MAX)) && (frac_s != 23'd0);

endmodule

// File: rtl/multiplier_pipe_floating_point32.sv
// Three-stage IEEE-754 single-precision multiplier: classify/unpack,
// mantissa multiply + exponent add, normalize/round/pack.
module multiplier_pipe_floating_point32
    import multiplier_pipe_floating_point32_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        out_valid,
    output logic [31:0] out,
    output logic        zero_flag,
    output logic        inf_flag,
    output logic        nan_flag,
    output logic        ovf_flag
);

    localparam logic signed [9:0] BIAS_S    = 10'(EXP_BIAS);
    localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;

    logic zero_a_s, inf_a_s, nan_a_s;
    logic zero_b_s, inf_b_s, nan_b_s;

    logic          sign1_q;
    logic [7:0]    exp_a1_q, exp_b1_q;
    logic [23:0]   man_a1_q, man_b1_q;
    result_class_e cls1_q;

    logic                sign2_q;
    logic [47:0]         prod2_q;
    logic signed [9:0]   exp2_q;
    logic signed [9:0]   exp2_d;
    result_class_e       cls2_q;

    logic [31:0]       out_q, out_d;
    logic              zero_q, zero_d, inf_q, inf_d, nan_q, nan_d, ovf_q, ovf_d;
    logic [23:0]       mant_s;
    logic              guard_s, sticky_s, round_up_s;
    logic [24:0]       mant_rnd_s;
    logic signed [9:0] exp_norm_s, exp_fin_s;
    logic [22:0]       frac_s;

    fp32_operand_classify u_class_a (
        .mag_i     (inA[30:0]),
        .is_zero_o (zero_a_s),
        .is_inf_o  (inf_a_s),
        .is_nan_o  (nan_a_s)
    );

    fp32_operand_classify u_class_b (
        .mag_i     (inB[30:0]),
        .is_zero_o (zero_b_s),
        .is_inf_o  (inf_b_s),
        .is_nan_o  (nan_b_s)
    );

    assign valid_d = {valid_q[LATENCY-2:0], in_valid};

    // Valid shift chain; reset discards every in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Stage 1: sign, operand class and unpacked fields with hidden bit.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            sign1_q  <= inA[31] ^ inB[31];
            exp_a1_q <= inA[30:23];
            exp_b1_q <= inB[30:23];
            man_a1_q <= {1'b1, inA[22:0]};
            man_b1_q <= {1'b1, inB[22:0]};
            cls1_q   <= classify_result(zero_a_s, inf_a_s, nan_a_s,
                                        zero_b_s, inf_b_s, nan_b_s);
        end
    end

    assign exp2_d = $signed({2'b00, exp_a1_q}) + $signed({2'b00, exp_b1_q}) - BIAS_S;

    // Stage 2: full mantissa product and re-biased exponent sum.
    always_ff @(posedge clk) begin
        if (valid_q[0]) begin
            sign2_q <= sign1_q;
            prod2_q <= man_a1_q * man_b1_q;
            exp2_q  <= exp2_d;
            cls2_q  <= cls1_q;
        end
    end

    // Stage 3 datapath: normalize, round-to-nearest-even, range check, special override.
    always_comb begin
        out_d  = 32'h0000_0000;
        zero_d = 1'b0;
        inf_d  = 1'b0;
        nan_d  = 1'b0;
        ovf_d  = 1'b0;
        if (prod2_q[47]) begin
            mant_s     = prod2_q[47:24];
            guard_s    = prod2_q[23];
            sticky_s   = |prod2_q[22:0];
            exp_norm_s = exp2_q + 10'sd1;
        end else begin
            mant_s     = prod2_q[46:23];
            guard_s    = prod2_q[22];
            sticky_s   = |prod2_q[21:0];
            exp_norm_s = exp2_q;
        end
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {24'd0, round_up_s};
        // A carry out of rounding leaves 1.000..., so the fraction is zero.
        if (mant_rnd_s[24]) begin
            exp_fin_s = exp_norm_s + 10'sd1;
            frac_s    = mant_rnd_s[23:1];
        end else begin
            exp_fin_s = exp_norm_s;
            frac_s    = mant_rnd_s[22:0];
        end
        case (cls2_q)
            CLS_NAN: begin
                out_d = QNAN;
                nan_d = 1'b1;
            end
            CLS_INF: begin
                out_d = {sign2_q, POS_INF[30:0]};
                inf_d = 1'b1;
            end
            CLS_ZERO: begin
                out_d  = {sign2_q, 31'd0};
                zero_d = 1'b1;
            end
            CLS_NORMAL: begin
                if (exp_fin_s >= EXP_MAX_S) begin
                    out_d = {sign2_q, POS_INF[30:0]};
                    inf_d = 1'b1;
                    ovf_d = 1'b1;
                end else if (exp_fin_s <= 10'sd0) begin
                    out_d  = {sign2_q, 31'd0};
                    zero_d = 1'b1;
                end else begin
                    out_d = {sign2_q, exp_fin_s[7:0], frac_s};
                end
            end
            default: begin
                out_d = QNAN;
                nan_d = 1'b1;
            end
        endcase
    end

    // Output register: loads on a stage-2 valid, otherwise holds the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= 32'h0000_0000;
            zero_q <= 1'b0;
            inf_q  <= 1'b0;
            nan_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (valid_q[LATENCY-2]) begin
            out_q  <= out_d;
            zero_q <= zero_d;
            inf_q  <= inf_d;
            nan_q  <= nan_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out       = out_q;
    assign zero_flag = zero_q;
    assign inf_flag  = inf_q;
    assign nan_flag  = nan_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_multiplier_pipe_floating_point32.sv
// Scoreboard bench for the FP32 multiplier: directed vectors with hand-computed
// products, a decoupled monitor checking value, flags, latency, hold and reset.
module tb_multiplier_pipe_floating_point32;

    localparam int NV = 19;
    localparam logic [3:0] F_NONE = 4'b0000;  // {zero, inf, nan, ovf}
    localparam logic [3:0] F_ZERO = 4'b1000;
    localparam logic [3:0] F_INF  = 4'b0100;
    localparam logic [3:0] F_NAN  = 4'b0010;
    localparam logic [3:0] F_OVF  = 4'b0101;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inA, inB;
    logic        out_valid;
    logic [31:0] out_w;
    logic        zero_flag, inf_flag, nan_flag, ovf_flag;
    logic [3:0]  flags_w;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          issue;
        int          idx;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_out = 32'h0;
    logic [3:0]  last_flags = 4'h0;

    logic [31:0] va [NV] = '{32'h40000000, 32'hBFC00000, 32'h3F800001, 32'h00000000,
                             32'h80000000, 32'h7E967699, 32'h00800000, 32'h7F800001,
                             32'hFF800000, 32'h3FC00000, 32'h3F800001, 32'h3F800003,
                             32'h3F800001, 32'h7F000000, 32'h7F000000, 32'h00800000,
                             32'h00800000, 32'h807FFFFF, 32'h7F800000};
    logic [31:0] vb [NV] = '{32'h40400000, 32'h40000000, 32'h3F800001, 32'h7F800000,
                             32'h3F800000, 32'h7E967699, 32'h00800000, 32'h3F800000,
                             32'h40000000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000,
                             32'h3FFFFFFE, 32'h3F800000, 32'h40000000, 32'h3F800000,
                             32'h3F000000, 32'h40000000, 32'h80000000};
    logic [31:0] vr [NV] = '{32'h40C00000, 32'hC0400000, 32'h3F800002, 32'h7FC00000,
                             32'h80000000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                             32'hFF800000, 32'h40100000, 32'h3FC00002, 32'h3FC00004,
                             32'h40000000, 32'h7F000000, 32'h7F800000, 32'h00800000,
                             32'h00000000, 32'h80000000, 32'h7FC00000};
    logic [3:0]  vf [NV] = '{F_NONE, F_NONE, F_NONE, F_NAN,
                             F_ZERO, F_OVF,  F_ZERO, F_NAN,
                             F_INF,  F_NONE, F_NONE, F_NONE,
                             F_NONE, F_NONE, F_OVF,  F_NONE,
                             F_ZERO, F_ZERO, F_NAN};

    multiplier_pipe_floating_point32 #(.LATENCY(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inA       (inA),
        .inB       (inB),
        .out_valid (out_valid),
        .out       (out_w),
        .zero_flag (zero_flag),
        .inf_flag  (inf_flag),
        .nan_flag  (nan_flag),
        .ovf_flag  (ovf_flag)
    );

    assign flags_w = {zero_flag, inf_flag, nan_flag, ovf_flag};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: reset state, scoreboard compare on out_valid, hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            checks++;
            if (out_valid !== 1'b0 || out_w !== 32'h0 || flags_w !== 4'h0) begin
                errors++;
                $display("FAIL reset_state: got valid=%b out=%h flags=%b, want 0/00000000/0000",
                         out_valid, out_w, flags_w);
            end
            last_out   = 32'h0;
            last_flags = 4'h0;
        end else if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got out=%h at cycle %0d, want no out_valid",
                         out_w, cyc);
            end else begin
                e = sb_q.pop_front();
                checks += 3;
                if (out_w !== e.res) begin
                    errors++;
                    $display("FAIL value[v%0d]: got %h, want %h", e.idx, out_w, e.res);
                end
                if (flags_w !== e.flg) begin
                    errors++;
                    $display("FAIL flags[v%0d]: got %b, want %b", e.idx, flags_w, e.flg);
                end
                if (cyc - e.issue != 3) begin
                    errors++;
                    $display("FAIL latency[v%0d]: got %0d, want 3", e.idx, cyc - e.issue);
                end
            end
            last_out   = out_w;
            last_flags = flags_w;
        end else begin
            checks++;
            if (out_valid !== 1'b0 || out_w !== last_out || flags_w !== last_flags) begin
                errors++;
                $display("FAIL hold: got valid=%b out=%h flags=%b, want 0/%h/%b",
                         out_valid, out_w, flags_w, last_out, last_flags);
            end
        end
    end

    task automatic issue(input int k);
        exp_t e;
        inA      = va[k];
        inB      = vb[k];
        in_valid = 1'b1;
        e.res    = vr[k];
        e.flg    = vf[k];
        e.issue  = cyc;
        e.idx    = k;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        inA      = 32'h0;
        inB      = 32'h0;
        #2 rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        for (int k = 0; k < NV; k++) begin
            issue(k);
            idle(4);
        end

        for (int i = 0; i < 10; i++) begin
            if (i == 5) idle(1);
            issue(i);
        end
        idle(6);

        issue(0);
        issue(1);
        rst = 1'b1;
        sb_q.delete();
        idle(2);
        rst = 1'b0;
        idle(6);
        issue(2);
        issue(12);

        for (int n = 0; n < 20 && sb_q.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, want 0", sb_q.size());
        end
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_pipe_floating_point32.md
MULTIPLIER_PIPE_FLOATING_POINT32 -- requirements
Module: multiplier_pipe_floating_point32

Interface
REQ-001 SHALL have parameter LATENCY, default 3, fixed pipeline depth in cycles; only 3 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-005 SHALL have port inA  input  32  IEEE-754 single operand A.
REQ-006 SHALL have port inB  input  32  IEEE-754 single operand B.
REQ-007 SHALL have port out_valid  output  1  result valid this cycle.
REQ-008 SHALL have port out  output  32  IEEE-754 single product.
REQ-009 SHALL have port zero_flag  output  1  result is +/-0.
REQ-010 SHALL have port inf_flag  output  1  result is +/-infinity.
REQ-011 SHALL have port nan_flag  output  1  result is NaN.
REQ-012 SHALL have port ovf_flag  output  1  finite operands overflowed to infinity.

Function
REQ-013 SHALL accept one operand pair per cycle whenever in_valid=1; no backpressure, no stall.
REQ-014 SHALL assert out_valid exactly 3 cycles after the accepting in_valid, in order, one result per accepted pair, with back-to-back throughput.
REQ-015 SHALL hold out/flags at their last values while out_valid=0.
REQ-016 Stage 1 SHALL register sign = A[31]^B[31], classify each operand (zero: exp==0, denormals flushed to zero; inf: exp==255, frac==0; NaN: exp==255, frac!=0), and prepend the hidden 1 to the mantissas.
REQ-017 Stage 2 SHALL register the 48-bit product of the two 24-bit mantissas and the 10-bit signed exponent sum expA+expB-127.
REQ-018 Stage 3 SHALL normalize (product bit47=1 -> shift right 1, exponent+1), round to nearest even on guard/sticky bits, and renormalize if rounding carries out.
REQ-019 SHALL produce the canonical NaN 0x7FC00000, nan_flag=1, if either operand is NaN or one operand is zero and the other infinity.
REQ-020 SHALL produce signed infinity, inf_flag=1, if either operand is infinity (REQ-019 excepted).
REQ-021 SHALL produce signed zero, zero_flag=1, if either operand is zero/denormal (REQ-019 excepted).
REQ-022 SHALL produce signed infinity with inf_flag=1 and ovf_flag=1 when the final biased exponent >= 255.
REQ-023 SHALL produce signed zero with zero_flag=1 when the final biased exponent <= 0; no denormal outputs.
REQ-024 SHALL give special cases (REQ-019..021) priority over arithmetic results; at most one of zero/inf/nan is set.

Reset
REQ-025 SHALL, while rst=1, asynchronously clear all valid bits, out=0x00000000, and all flags to 0.
REQ-026 SHALL discard all in-flight operations on reset mid-operation; the first out_valid after rst falls SHALL be 3 cycles after the first post-reset in_valid.
REQ-027 Datapath registers other than out SHALL need no reset; valid bits and flags SHALL.

Structure
REQ-028 Shared package SHALL hold the FP32 field constants (EXP_BIAS=127, EXP_MAX=255, QNAN=0x7FC00000, POS_INF=0x7F800000).
REQ-029 SHALL instantiate one sub-module, fp32_operand_classify, combinational, returning is_zero/is_inf/is_nan per operand; used twice in stage 1.

Verification
REQ-030 0x40000000 x 0x40400000 (2.0x3.0) -> out=0x40C00000, out_valid exactly 3 cycles later, all flags 0.
REQ-031 0xBFC00000 x 0x40000000 (-1.5x2.0) -> 0xC0400000; 0x3F800001 x 0x3F800001 -> 0x3F800002 (rounding).
REQ-032 0x00000000 x 0x7F800000 -> 0x7FC00000 nan_flag=1; 0x80000000 x 0x3F800000 -> 0x80000000 zero_flag=1.
REQ-033 0x7E967699 x 0x7E967699 (1e38^2) -> 0x7F800000, inf_flag=1, ovf_flag=1; 0x00800000 x 0x00800000 -> 0x00000000, zero_flag=1.
REQ-034 10 back-to-back in_valid pairs with one gap -> 10 in-order results, same gap shifted 3 cycles.
REQ-035 rst pulsed with 2 operations in flight -> out_valid stays 0, no stale result after release.
